// File: rtl/i2c_pkg.sv
// Shared types and helpers for the multi-channel I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer plus edge/condition detect; events appear SYNC_STAGES cycles after the pad
// change and are acted on one cycle later. No backpressure.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic system_clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_p, sda_p, scl_s;

  // Idle bus is high; resetting to 1 avoids phantom conditions on release.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl_in};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda_in};
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  assign scl_s     = scl_q[SYNC_STAGES-1];
  assign sda_s     = sda_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_target_mc.sv
// Multi-channel I2C target on system_clk: NUM_CHAN addresses, streamed write bytes, word-based reads.
// A write byte arriving with rx_ready=0 is NACKed (rx_drop) and the target ignores the bus until STOP/Sr.
module i2c_target_mc
  import i2c_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter int         NUM_CHAN      = 4,
  parameter logic [6:0] BASE_ADDR     = 7'h70,
  parameter int         RD_WORD_BYTES = 4,
  parameter logic [7:0] FILL_BYTE     = 8'hFF
) (
  input  logic                            system_clk,
  input  logic                            reset,
  input  logic                            scl_in,
  input  logic                            sda_in,
  output logic                            sda_oe,
  output logic [7:0]                      rx_data,
  output logic [chan_width(NUM_CHAN)-1:0] rx_chan,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  input  logic [8*RD_WORD_BYTES-1:0]      tx_word,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [chan_width(NUM_CHAN)-1:0] tx_chan,
  output logic                            busy,
  output logic                            rx_drop
);
  localparam int CW = chan_width(NUM_CHAN);
  localparam int WW = 8 * RD_WORD_BYTES;
  localparam int IW = (RD_WORD_BYTES > 1) ? $clog2(RD_WORD_BYTES) : 1;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .system_clk(system_clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_t    state;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          byte_done, rw;
  logic [CW-1:0] chan;
  logic [IW-1:0] byte_idx;
  logic [WW-1:0] tx_buf;

  logic [7:0]    rx_byte, addr_off;
  logic          addr_hit, rd_load;
  logic [WW-1:0] next_word, rd_src;

  assign rx_byte   = {shreg, sda_s};
  assign addr_off  = {1'b0, rx_byte[7:1]} - {1'b0, BASE_ADDR};
  assign addr_hit  = (rx_byte[7:1] >= BASE_ADDR) && (addr_off < 8'(NUM_CHAN));
  assign next_word = tx_valid ? tx_word : {RD_WORD_BYTES{FILL_BYTE}};
  // A fresh word is needed at the first read byte and whenever the byte index wraps.
  assign rd_load   = (state == ADDR_ACK) || (byte_idx == '0);
  assign rd_src    = rd_load ? next_word : tx_buf;

  always_ff @(posedge system_clk) begin
    rx_valid <= 1'b0;
    tx_ready <= 1'b0;
    rx_drop  <= 1'b0;
    if (reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= '0;
      rx_chan   <= '0;
      tx_chan   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      chan      <= '0;
      byte_idx  <= '0;
      tx_buf    <= '0;
    end else if (stop_det) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else if (start_det) begin
      state     <= ADDR;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ADDR, WR_DATA: begin
          if (scl_rise && !byte_done) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                if (addr_hit) begin
                  byte_done <= 1'b1;
                  rw        <= rx_byte[0];
                  chan      <= addr_off[CW-1:0];
                end else begin
                  state <= WAIT_STOP;
                end
              end else if (rx_ready) begin
                byte_done <= 1'b1;
                rx_valid  <= 1'b1;
                rx_data   <= rx_byte;
                rx_chan   <= chan;
              end else begin
                rx_drop <= 1'b1;
                state   <= WAIT_STOP;
              end
            end
          end else if (scl_fall && byte_done) begin
            byte_done <= 1'b0;
            sda_oe    <= 1'b1;
            state     <= (state == ADDR) ? ADDR_ACK : WR_ACK;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!rw) begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= WR_DATA;
          end else begin
            byte_idx <= '0;
            tx_chan  <= chan;
            tx_ready <= tx_valid;
            sda_oe   <= ~rd_src[WW-1];
            tx_buf   <= {rd_src[WW-2:0], 1'b0};
            bit_cnt  <= 3'd1;
            state    <= RD_DATA;
          end
        end
        WR_ACK: if (scl_fall) begin
          sda_oe  <= 1'b0;
          bit_cnt <= '0;
          state   <= WR_DATA;
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == 3'd0) begin
            sda_oe <= 1'b0;
            state  <= RD_ACK;
          end else begin
            sda_oe  <= ~tx_buf[WW-1];
            tx_buf  <= {tx_buf[WW-2:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) state <= WAIT_STOP;
            else byte_idx <= (byte_idx == IW'(RD_WORD_BYTES - 1)) ? '0 : byte_idx + 1'b1;
          end else if (scl_fall) begin
            tx_ready <= rd_load & tx_valid;
            sda_oe   <= ~rd_src[WW-1];
            tx_buf   <= {rd_src[WW-2:0], 1'b0};
            bit_cnt  <= 3'd1;
            state    <= RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_mc.sv
// Directed bench for i2c_target_mc: a bus-level controller model driving table vectors plus
// hand-written repeated-start, mid-read STOP and mid-ACK reset sequences.
module tb_i2c_target_mc;
  import i2c_pkg::*;

  localparam int Q = 40;  // quarter SCL period in ns (SCL = 16 system clocks)

  logic        system_clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_oe, rx_valid, rx_ready = 1'b1, tx_valid = 1'b0, tx_ready, busy, rx_drop;
  logic [7:0]  rx_data;
  logic [1:0]  rx_chan, tx_chan;
  logic [31:0] tx_word = '0;
  logic        scl_in, sda_in;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 system_clk = ~system_clk;

  i2c_target_mc dut (
    .system_clk(system_clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_chan(rx_chan), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_chan(tx_chan), .busy(busy), .rx_drop(rx_drop)
  );

  int total = 0, bad = 0;
  logic [7:0] rxq_data[$];
  logic [1:0] rxq_chan[$];
  int n_txr = 0, n_drop = 0;
  logic oe_seen = 1'b0;

  always @(negedge system_clk) begin
    if (rx_valid) begin
      rxq_data.push_back(rx_data);
      rxq_chan.push_back(rx_chan);
    end
    if (tx_ready) n_txr++;
    if (rx_drop) n_drop++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_in; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  typedef struct {
    string       name;
    logic [6:0]  addr;
    logic        rw;
    int          nbytes;
    logic [47:0] data;     // write bytes or expected read bytes, first byte in [47:40]
    logic [5:0]  rdy;      // rx_ready per write byte, bit i = byte i
    logic        tx_valid;
    logic [31:0] word;
    logic        addr_ack;
    int          n_rxv;
    int          n_drop;
    int          n_txr;
    logic [3:0]  chan;
  } vec_t;

  vec_t v[8];

  initial begin
    logic       a, acc;
    logic [7:0] b;

    v[0] = '{"wr72",     7'h72, 1'b0, 2, 48'hA53C_0000_0000, 6'b000011, 1'b0, 32'h0,        1'b1, 2, 0, 0, 4'd2};
    v[1] = '{"wr74",     7'h74, 1'b0, 0, 48'h0,              6'b000000, 1'b0, 32'h0,        1'b0, 0, 0, 0, 4'd0};
    v[2] = '{"rd71",     7'h71, 1'b1, 4, 48'hDEAD_BEEF_0000, 6'b000000, 1'b1, 32'hDEADBEEF, 1'b1, 0, 0, 1, 4'd1};
    v[3] = '{"rd70fill", 7'h70, 1'b1, 6, 48'hFFFF_FFFF_FFFF, 6'b000000, 1'b0, 32'h12345678, 1'b1, 0, 0, 0, 4'd0};
    v[4] = '{"wr73drop", 7'h73, 1'b0, 2, 48'h1122_0000_0000, 6'b000001, 1'b0, 32'h0,        1'b1, 1, 1, 0, 4'd3};
    v[5] = '{"rd73wrap", 7'h73, 1'b1, 6, 48'h1122_3344_1122, 6'b000000, 1'b1, 32'h11223344, 1'b1, 0, 0, 2, 4'd3};
    v[6] = '{"wr6F",     7'h6F, 1'b0, 0, 48'h0,              6'b000000, 1'b0, 32'h0,        1'b0, 0, 0, 0, 4'd0};
    v[7] = '{"wr70",     7'h70, 1'b0, 1, 48'h5A00_0000_0000, 6'b000001, 1'b0, 32'h0,        1'b1, 1, 0, 0, 4'd0};

    repeat (5) @(posedge system_clk);
    #1;
    chk("rst.sda_oe", sda_oe, 0);
    chk("rst.rx_valid", rx_valid, 0);
    chk("rst.tx_ready", tx_ready, 0);
    chk("rst.rx_drop", rx_drop, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rx_data", rx_data, 0);
    chk("rst.rx_chan", rx_chan, 0);
    chk("rst.tx_chan", tx_chan, 0);
    @(negedge system_clk);
    reset = 1'b0;
    #(4*Q);

    for (int k = 0; k < 8; k++) begin
      rxq_data.delete(); rxq_chan.delete();
      n_txr = 0; n_drop = 0; oe_seen = 1'b0;
      tx_valid = v[k].tx_valid; tx_word = v[k].word; rx_ready = 1'b1;
      i2c_start();
      write_byte({v[k].addr, v[k].rw}, a);
      chk($sformatf("%s.addr_ack", v[k].name), a, v[k].addr_ack ? 0 : 1);
      chk($sformatf("%s.busy", v[k].name), busy, 1);
      if (!v[k].rw) begin
        acc = v[k].addr_ack;
        for (int i = 0; i < v[k].nbytes; i++) begin
          rx_ready = v[k].rdy[i];
          acc = acc & v[k].rdy[i];
          write_byte(v[k].data[47-8*i -: 8], a);
          chk($sformatf("%s.byte%0d_ack", v[k].name, i), a, acc ? 0 : 1);
        end
      end else if (v[k].addr_ack) begin
        for (int i = 0; i < v[k].nbytes; i++) begin
          read_byte(b, (i == v[k].nbytes - 1) ? NACK : ACK);
          chk($sformatf("%s.rd%0d", v[k].name, i), b, v[k].data[47-8*i -: 8]);
        end
        chk($sformatf("%s.tx_chan", v[k].name), tx_chan, v[k].chan);
      end
      i2c_stop();
      rx_ready = 1'b1;
      chk($sformatf("%s.busy_after", v[k].name), busy, 0);
      chk($sformatf("%s.sda_oe_after", v[k].name), sda_oe, 0);
      chk($sformatf("%s.n_rx_valid", v[k].name), rxq_data.size(), v[k].n_rxv);
      chk($sformatf("%s.n_rx_drop", v[k].name), n_drop, v[k].n_drop);
      chk($sformatf("%s.n_tx_ready", v[k].name), n_txr, v[k].n_txr);
      for (int i = 0; i < v[k].n_rxv && i < rxq_data.size(); i++) begin
        chk($sformatf("%s.rx_data%0d", v[k].name, i), rxq_data[i], v[k].data[47-8*i -: 8]);
        chk($sformatf("%s.rx_chan%0d", v[k].name, i), rxq_chan[i], v[k].chan);
      end
      if (!v[k].addr_ack) chk($sformatf("%s.oe_seen", v[k].name), oe_seen, 0);
      #(2*Q);
    end

    // Repeated start in the middle of a write byte, then a read aborted by STOP.
    rxq_data.delete(); n_txr = 0;
    tx_valid = 1'b0; rx_ready = 1'b1;
    i2c_start();
    write_byte({7'h72, 1'b0}, a);
    chk("sr.addr_ack", a, 0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q;
    chk("sr.state", dut.state, ADDR);
    chk("sr.sda_oe", sda_oe, 0);
    scl_m = 1'b0; #Q;
    write_byte({7'h71, 1'b1}, a);
    chk("sr.rd_addr_ack", a, 0);
    for (int i = 0; i < 3; i++) begin
      read_bit(a);
      chk($sformatf("sr.fill_bit%0d", i), a, 1);
    end
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    chk("pstop.state", dut.state, IDLE);
    chk("pstop.sda_oe", sda_oe, 0);
    chk("pstop.busy", busy, 0);
    chk("pstop.n_rx_valid", rxq_data.size(), 0);
    chk("pstop.n_tx_ready", n_txr, 0);
    chk("pstop.tx_chan", tx_chan, 1);
    #(2*Q);

    // Reset asserted while the target is driving an address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : ((8'hE0 >> i) & 1));
    sda_m = 1'b1; #Q;
    chk("rack.sda_oe_before", sda_oe, 1);
    scl_m = 1'b1; #Q;
    reset = 1'b1;
    @(posedge system_clk); #1;
    chk("rack.sda_oe", sda_oe, 0);
    chk("rack.state", dut.state, IDLE);
    chk("rack.busy", busy, 0);
    @(negedge system_clk);
    reset = 1'b0;
    scl_m = 1'b0; #Q;
    i2c_stop();
    chk("rack.n_rx_valid", rxq_data.size(), 0);
    chk("rack.busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
